checker_page_scan: RTL and testbench

CHECKER_PAGE_SCAN -- requirements
Module: checker_page_scan

---
 rtl/checker_page_scan_pkg.sv | 30 +++
 rtl/checker_rd_watchdog.sv | 33 +++
 rtl/checker_page_scan.sv | 182 ++++++++++++++++++
 tb/tb_checker_page_scan.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checker_page_scan_pkg.sv
// Shared encodings for the page scanner: mode selects, FSM states and page geometry.
package checker_page_scan_pkg;

  typedef enum logic [1:0] {
    CHECKER_MODE_SINGLE = 2'd0,
    CHECKER_MODE_AUTO   = 2'd1,
    CHECKER_MODE_READ   = 2'd2,
    CHECKER_MODE_DUMMY  = 2'd3
  } checker_mode_e;

  typedef enum logic [2:0] {
    CHECKER_SCAN_IDLE     = 3'd0,
    CHECKER_SCAN_ISSUE    = 3'd1,
    CHECKER_SCAN_WAIT_RD  = 3'd2,
    CHECKER_SCAN_IRQ      = 3'd3,
    CHECKER_SCAN_ACK_WAIT = 3'd4,
    CHECKER_SCAN_DONE     = 3'd5,
    CHECKER_SCAN_HOLD     = 3'd6
  } checker_scan_state_e;

  localparam int unsigned PAGE_QWORDS = 512;
  localparam logic [8:0]  LAST_INDEX  = 9'(PAGE_QWORDS - 1);

  // Quad-word address inside a 4 KiB page: page number, qword index, byte offset 0.
  function automatic logic [63:0] page_qword_addr(input logic [51:0] page,
                                                  input logic [8:0]  idx);
    return {page, idx, 3'b000};
  endfunction

endpackage

// File: rtl/checker_rd_watchdog.sv
// Read watchdog: cleared before each read, counts while the read is outstanding,
// flags expiry on the TIMEOUT-th outstanding cycle.
module checker_rd_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expire
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == LIMIT);
  assign o_expire   = i_start && w_at_limit;

  // Count outstanding cycles; saturate at the limit so the flag cannot wrap away.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_start && !w_at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/checker_page_scan.sv
// Page scanner: single read, or a 512-qword page scan looking for MAGIC in the
// upper word, with irq/ack handshake per hit, watchdog and abort support.
module checker_page_scan
  import checker_page_scan_pkg::*;
#(
  parameter logic [31:0] MAGIC   = 32'h4D5A9000,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        mode_start,
  input  logic [1:0]  mode_mode,
  input  logic [63:0] mode_addr,
  input  logic        mode_ack,
  output logic        mode_end,
  output logic        mode_error,
  output logic        mode_irq,
  output logic [63:0] mode_data,
  output logic        rd_req,
  output logic [63:0] rd_addr,
  input  logic        rd_ack,
  input  logic [63:0] rd_data,
  input  logic        rd_err
);

  checker_scan_state_e r_state;
  logic                r_single;
  logic [8:0]          r_index;
  logic                r_mode_end;
  logic                r_mode_error;
  logic                r_mode_irq;
  logic                r_rd_req;
  logic [63:0]         r_mode_data;
  logic [63:0]         r_rd_addr;

  checker_mode_e       w_mode;
  logic                w_abort;
  logic                w_rd_ack;
  logic                w_rd_err;
  logic                w_match;
  logic                w_last;
  logic                w_wd_run;
  logic                w_wd_clear;
  logic                w_wd_expire;

  assign w_mode     = checker_mode_e'(mode_mode);
  assign w_abort    = !mode_start && (r_state != CHECKER_SCAN_IDLE) &&
                      (r_state != CHECKER_SCAN_HOLD);
  assign w_rd_ack   = rd_ack && r_rd_req;
  assign w_rd_err   = rd_err && r_rd_req;
  assign w_match    = (rd_data[63:32] == MAGIC);
  assign w_last     = (r_index == LAST_INDEX);
  assign w_wd_clear = (r_state == CHECKER_SCAN_ISSUE);
  assign w_wd_run   = (r_state == CHECKER_SCAN_WAIT_RD);

  checker_rd_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_rd_watchdog (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_start  (w_wd_run),
    .i_clear  (w_wd_clear),
    .o_expire (w_wd_expire)
  );

  // Scan FSM with registered pulses, read request/address and result register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= CHECKER_SCAN_IDLE;
      r_single     <= 1'b0;
      r_index      <= '0;
      r_mode_end   <= 1'b0;
      r_mode_error <= 1'b0;
      r_mode_irq   <= 1'b0;
      r_rd_req     <= 1'b0;
      r_mode_data  <= '0;
      r_rd_addr    <= '0;
    end else begin
      r_mode_end   <= 1'b0;
      r_mode_error <= 1'b0;
      r_mode_irq   <= 1'b0;
      if (w_abort) begin
        r_rd_req <= 1'b0;
        r_state  <= CHECKER_SCAN_IDLE;
      end else begin
        case (r_state)
          CHECKER_SCAN_IDLE: begin
            if (mode_start) begin
              case (w_mode)
                CHECKER_MODE_DUMMY: begin
                  r_mode_end <= 1'b1;
                  r_state    <= CHECKER_SCAN_HOLD;
                end
                CHECKER_MODE_AUTO: begin
                  r_mode_error <= 1'b1;
                  r_state      <= CHECKER_SCAN_HOLD;
                end
                CHECKER_MODE_SINGLE: begin
                  if (mode_addr[11:0] != '0) begin
                    r_mode_error <= 1'b1;
                    r_state      <= CHECKER_SCAN_HOLD;
                  end else begin
                    r_single <= 1'b1;
                    r_index  <= '0;
                    r_state  <= CHECKER_SCAN_ISSUE;
                  end
                end
                CHECKER_MODE_READ: begin
                  if (mode_addr[2:0] != '0) begin
                    r_mode_error <= 1'b1;
                    r_state      <= CHECKER_SCAN_HOLD;
                  end else begin
                    r_single <= 1'b0;
                    r_state  <= CHECKER_SCAN_ISSUE;
                  end
                end
                default: r_state <= CHECKER_SCAN_IDLE;
              endcase
            end
          end
          CHECKER_SCAN_ISSUE: begin
            r_rd_addr <= r_single ? page_qword_addr(mode_addr[63:12], r_index) : mode_addr;
            r_rd_req  <= 1'b1;
            r_state   <= CHECKER_SCAN_WAIT_RD;
          end
          CHECKER_SCAN_WAIT_RD: begin
            if (w_rd_err || w_wd_expire) begin
              r_rd_req     <= 1'b0;
              r_mode_error <= 1'b1;
              r_state      <= CHECKER_SCAN_HOLD;
            end else if (w_rd_ack) begin
              r_rd_req <= 1'b0;
              if (!r_single) begin
                r_mode_data <= rd_data;
                r_mode_end  <= 1'b1;
                r_state     <= CHECKER_SCAN_HOLD;
              end else if (w_match) begin
                r_mode_data <= r_rd_addr;
                r_state     <= CHECKER_SCAN_IRQ;
              end else if (w_last) begin
                r_state <= CHECKER_SCAN_DONE;
              end else begin
                r_index <= r_index + 1'b1;
                r_state <= CHECKER_SCAN_ISSUE;
              end
            end
          end
          CHECKER_SCAN_IRQ: begin
            r_mode_irq <= 1'b1;
            r_state    <= CHECKER_SCAN_ACK_WAIT;
          end
          CHECKER_SCAN_ACK_WAIT: begin
            if (mode_ack) begin
              if (w_last) begin
                r_state <= CHECKER_SCAN_DONE;
              end else begin
                r_index <= r_index + 1'b1;
                r_state <= CHECKER_SCAN_ISSUE;
              end
            end
          end
          CHECKER_SCAN_DONE: begin
            r_mode_end <= 1'b1;
            r_state    <= CHECKER_SCAN_HOLD;
          end
          CHECKER_SCAN_HOLD: begin
            if (!mode_start) r_state <= CHECKER_SCAN_IDLE;
          end
          default: r_state <= CHECKER_SCAN_IDLE;
        endcase
      end
    end
  end

  assign mode_end   = r_mode_end;
  assign mode_error = r_mode_error;
  assign mode_irq   = r_mode_irq;
  assign mode_data  = r_mode_data;
  assign rd_req     = r_rd_req;
  assign rd_addr    = r_rd_addr;

endmodule

// File: tb/tb_checker_page_scan.sv
// Directed bench for checker_page_scan: decode table plus read, scan, error,
// timeout, abort and reset sequences against a behavioural memory responder.
module tb_checker_page_scan;

  localparam logic [31:0] MAGIC   = 32'h4D5A9000;
  localparam int unsigned TIMEOUT = 256;

  logic        sys_clk    = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic        mode_start = 1'b0;
  logic [1:0]  mode_mode  = 2'd0;
  logic [63:0] mode_addr  = '0;
  logic        mode_ack   = 1'b0;
  logic        mode_end, mode_error, mode_irq, rd_req;
  logic [63:0] mode_data, rd_addr;
  logic        rd_ack, rd_err;
  logic [63:0] rd_data;

  checker_page_scan #(
    .MAGIC   (MAGIC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .mode_start (mode_start),
    .mode_mode  (mode_mode),
    .mode_addr  (mode_addr),
    .mode_ack   (mode_ack),
    .mode_end   (mode_end),
    .mode_error (mode_error),
    .mode_irq   (mode_irq),
    .mode_data  (mode_data),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .rd_err     (rd_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_mis = 0;
  int n_end = 0, n_err = 0, n_irq = 0, excl_viol = 0;

  // memory responder controls
  bit          mem_noack = 0, mem_fixed = 0, mem_err_en = 0, mem_magic_en = 0, mem_inject = 0;
  int          mem_lat = 1;
  logic [8:0]  mem_err_idx = '0, mem_magic_a = '0, mem_magic_b = '0;
  logic [63:0] mem_fixed_data = '0;
  int          n_reads = 0;
  logic [63:0] first_addr = '0;
  bit          mem_busy = 0;
  int          mem_wait = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] addr;
    logic        exp_end;
    logic        exp_err;
  } vec_t;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return mode_end;
      1:       return mode_error;
      2:       return mode_irq;
      default: return rd_req;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (sig(which) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [8:0] q;
    q = a[11:3];
    if (mem_fixed) return mem_fixed_data;
    if (mem_magic_en && (q == mem_magic_a || q == mem_magic_b)) return {MAGIC, a[31:0]};
    return {32'hA5A5_0000, a[31:0]};
  endfunction

  // Behavioural memory: latency in samples, optional error on one qword, optional silence.
  initial begin : memory
    rd_ack  = 1'b0;
    rd_err  = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      rd_ack = 1'b0;
      rd_err = 1'b0;
      if (mem_inject) begin
        rd_ack     = 1'b1;
        rd_data    = {MAGIC, 32'h0};
        mem_inject = 0;
      end else if (!sys_rst_n || !rd_req) begin
        mem_busy = 0;
      end else begin
        if (!mem_busy) begin
          mem_busy = 1;
          mem_wait = 1;
          if (n_reads == 0) first_addr = rd_addr;
          n_reads++;
        end else begin
          mem_wait++;
        end
        if (!mem_noack && mem_wait >= mem_lat) begin
          mem_busy = 0;
          if (mem_err_en && rd_addr[11:3] == mem_err_idx) rd_err = 1'b1;
          else begin
            rd_ack  = 1'b1;
            rd_data = mem_word(rd_addr);
          end
        end
      end
    end
  end

  // Pulse counters and exclusivity monitor, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (mode_end)   n_end++;
      if (mode_error) n_err++;
      if (mode_irq)   n_irq++;
      if ((int'(mode_end) + int'(mode_error) + int'(mode_irq)) > 1) excl_viol++;
    end
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    vec_t vecs [7];
    bit   ok;
    int   b_end, b_err, b_irq, a, b;

    vecs[0] = '{mode: 2'd3, addr: 64'h0,                   exp_end: 1'b1, exp_err: 1'b0};
    vecs[1] = '{mode: 2'd1, addr: 64'h0,                   exp_end: 1'b0, exp_err: 1'b1};
    vecs[2] = '{mode: 2'd0, addr: 64'h2004,                exp_end: 1'b0, exp_err: 1'b1};
    vecs[3] = '{mode: 2'd2, addr: 64'h1004,                exp_end: 1'b0, exp_err: 1'b1};
    vecs[4] = '{mode: 2'd0, addr: 64'h2800,                exp_end: 1'b0, exp_err: 1'b1};
    vecs[5] = '{mode: 2'd3, addr: 64'hFFFF_FFFF_FFFF_FFFF, exp_end: 1'b1, exp_err: 1'b0};
    vecs[6] = '{mode: 2'd2, addr: 64'h1001,                exp_end: 1'b0, exp_err: 1'b1};

    // reset state
    tick(2);
    chk("rst_mode_end",   64'(mode_end),   64'd0);
    chk("rst_mode_error", 64'(mode_error), 64'd0);
    chk("rst_mode_irq",   64'(mode_irq),   64'd0);
    chk("rst_rd_req",     64'(rd_req),     64'd0);
    chk("rst_mode_data",  mode_data,       64'd0);
    chk("rst_rd_addr",    rd_addr,         64'd0);
    sys_rst_n = 1'b1;
    tick(2);

    // immediate decode outcomes; start held to confirm HOLD blocks re-trigger
    for (int i = 0; i < 7; i++) begin
      n_reads = 0; b_end = n_end; b_err = n_err;
      mode_mode = vecs[i].mode; mode_addr = vecs[i].addr; mode_start = 1'b1;
      tick();
      chk($sformatf("vec%0d_end", i),   64'(mode_end),   64'(vecs[i].exp_end));
      chk($sformatf("vec%0d_error", i), 64'(mode_error), 64'(vecs[i].exp_err));
      tick(4);
      chk($sformatf("vec%0d_reads", i),  64'(n_reads), 64'd0);
      chk($sformatf("vec%0d_pulses", i), 64'((n_end - b_end) + (n_err - b_err)), 64'd1);
      mode_start = 1'b0;
      tick(3);
      chk($sformatf("vec%0d_idle", i), 64'(mode_end | mode_error | rd_req), 64'd0);
    end

    // READ: one read, data captured, one end pulse
    mem_fixed = 1; mem_fixed_data = 64'hDEADBEEF_CAFEF00D; mem_lat = 5;
    n_reads = 0; b_end = n_end; b_err = n_err;
    mode_mode = 2'd2; mode_addr = 64'h1000_0008; mode_start = 1'b1;
    wait_sig(0, 100, ok);
    chk("read_end_seen", 64'(ok), 64'd1);
    chk("read_data", mode_data, 64'hDEADBEEF_CAFEF00D);
    tick(3);
    chk("read_nreads", 64'(n_reads), 64'd1);
    chk("read_addr",   first_addr,   64'h1000_0008);
    chk("read_nend",   64'(n_end - b_end), 64'd1);
    chk("read_nerr",   64'(n_err - b_err), 64'd0);
    mode_start = 1'b0; mem_fixed = 0; mem_lat = 1;
    tick(2);

    // SINGLE scan with hits at qwords 3 and 511
    mem_magic_en = 1; mem_magic_a = 9'd3; mem_magic_b = 9'd511;
    n_reads = 0; b_end = n_end; b_err = n_err; b_irq = n_irq;
    mode_mode = 2'd0; mode_addr = 64'h2000; mode_start = 1'b1;
    wait_sig(2, 100, ok);
    chk("scan_irq1_seen", 64'(ok), 64'd1);
    chk("scan_irq1_data", mode_data, 64'h2018);
    tick();
    chk("scan_irq1_width", 64'(mode_irq), 64'd0);
    tick();
    mode_ack = 1'b1; tick(); mode_ack = 1'b0;
    wait_sig(2, 3000, ok);
    chk("scan_irq2_seen", 64'(ok), 64'd1);
    chk("scan_irq2_data", mode_data, 64'h2FF8);
    tick(2);
    mode_ack = 1'b1; tick(); mode_ack = 1'b0;
    wait_sig(0, 20, ok);
    chk("scan_end_seen", 64'(ok), 64'd1);
    tick(3);
    chk("scan_nreads", 64'(n_reads), 64'd512);
    chk("scan_nirq",   64'(n_irq - b_irq), 64'd2);
    chk("scan_nend",   64'(n_end - b_end), 64'd1);
    chk("scan_nerr",   64'(n_err - b_err), 64'd0);
    chk("scan_data_kept", mode_data, 64'h2FF8);
    mode_start = 1'b0; mem_magic_en = 0;
    tick(2);

    // bus error on qword 7 stops the scan
    mem_err_en = 1; mem_err_idx = 9'd7;
    n_reads = 0; b_end = n_end;
    mode_mode = 2'd0; mode_addr = 64'h3000; mode_start = 1'b1;
    wait_sig(1, 200, ok);
    chk("rderr_seen", 64'(ok), 64'd1);
    tick(5);
    chk("rderr_nreads", 64'(n_reads), 64'd8);
    chk("rderr_rd_req", 64'(rd_req),  64'd0);
    chk("rderr_nend",   64'(n_end - b_end), 64'd0);
    mode_start = 1'b0; mem_err_en = 0;
    tick(2);

    // watchdog: error exactly TIMEOUT cycles after rd_req rises
    mem_noack = 1; n_reads = 0;
    mode_mode = 2'd2; mode_addr = 64'h4000; mode_start = 1'b1;
    a = -1; b = -1; ok = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (a < 0 && rd_req) a = c;
      if (mode_error) begin
        b = c; ok = 1'b1;
        break;
      end
    end
    chk("tmo_seen",    64'(ok),    64'd1);
    chk("tmo_latency", 64'(b - a), 64'(TIMEOUT));
    chk("tmo_rd_req",  64'(rd_req), 64'd0);
    mode_start = 1'b0; mem_noack = 0;
    tick(2);

    // abort in ACK_WAIT
    mem_magic_en = 1; mem_magic_a = 9'd3; mem_magic_b = 9'd3;
    n_reads = 0; b_end = n_end; b_err = n_err; b_irq = n_irq;
    mode_mode = 2'd0; mode_addr = 64'h5000; mode_start = 1'b1;
    wait_sig(2, 100, ok);
    chk("abort1_irq_seen", 64'(ok), 64'd1);
    tick(2);
    mode_start = 1'b0;
    tick();
    chk("abort1_rd_req", 64'(rd_req), 64'd0);
    tick(3);
    chk("abort1_pulses", 64'((n_end - b_end) + (n_err - b_err) + (n_irq - b_irq)), 64'd1);
    chk("abort1_data",   mode_data, 64'h5018);
    chk("abort1_reads",  64'(n_reads), 64'd4);

    // abort in WAIT_RD, after restarting from index 0
    mem_noack = 1; n_reads = 0; b_end = n_end; b_err = n_err; b_irq = n_irq;
    mode_start = 1'b1;
    wait_sig(3, 10, ok);
    chk("abort2_req_seen", 64'(ok), 64'd1);
    chk("abort2_rescan",   first_addr, 64'h5000);
    tick(3);
    mode_start = 1'b0;
    tick();
    chk("abort2_rd_req", 64'(rd_req), 64'd0);
    tick(3);
    chk("abort2_pulses", 64'((n_end - b_end) + (n_err - b_err) + (n_irq - b_irq)), 64'd0);
    chk("abort2_data",   mode_data, 64'h5018);

    // fresh start rescans from qword 0 and finds the hit again
    mem_noack = 0; n_reads = 0;
    mode_start = 1'b1;
    wait_sig(2, 100, ok);
    chk("restart_irq_seen", 64'(ok), 64'd1);
    chk("restart_first",    first_addr, 64'h5000);
    chk("restart_reads",    64'(n_reads), 64'd4);
    mode_start = 1'b0; mem_magic_en = 0;
    tick(3);

    // asynchronous reset mid-read; late acks ignored
    mem_noack = 1; n_reads = 0; b_end = n_end; b_err = n_err;
    mode_mode = 2'd2; mode_addr = 64'h6000; mode_start = 1'b1;
    wait_sig(3, 10, ok);
    chk("rst_req_seen", 64'(ok), 64'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_rd_req",    64'(rd_req),     64'd0);
    chk("arst_mode_data", mode_data,       64'd0);
    chk("arst_rd_addr",   rd_addr,         64'd0);
    chk("arst_pulses",    64'(mode_end | mode_error | mode_irq), 64'd0);
    mode_start = 1'b0; mem_noack = 0;
    tick();
    mem_inject = 1;
    tick(2);
    sys_rst_n = 1'b1;
    mem_inject = 1;
    tick(4);
    chk("late_ack_data",   mode_data, 64'd0);
    chk("late_ack_rd_req", 64'(rd_req), 64'd0);
    chk("late_ack_pulses", 64'((n_end - b_end) + (n_err - b_err)), 64'd0);
    chk("late_ack_reads",  64'(n_reads), 64'd1);

    chk("pulse_exclusive", 64'(excl_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
